mult_seq_4b: RTL and testbench
==============================

Name: mult_seq_4b

Overview:
- Multi-cycle shift-and-add unsigned multiplier with valid/ready handshakes on both input and output.
- Sits in the execute path alongside the combinational 4-bit multiplier.
- Produces the full 2*WIDTH-bit product instead of a truncated WIDTH-bit one.
- Feeds its result to the writeback/register stage.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands x, y present
- in_ready  output  1  block can accept operands
- x  input  WIDTH  multiplicand, unsigned
- y  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product available on out
- out_ready  input  1  consumer accepts product
- out  output  2*WIDTH  product x*y
- busy  output  1  high in CALC or DONE

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-calculation):
  - state=IDLE.
  - out=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
  - All internal registers (mcand, mplier, acc, cnt) cleared.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, DONE. Encoding is free.
- Decoded outputs: in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - On an edge with in_valid&&in_ready, latch mcand = {WIDTH'b0, x} and mplier = y.
  - Clear acc and cnt, then go to CALC.
  - Otherwise stay in IDLE.
- CALC, one step per edge:
  - If mplier[0]=1: acc += mcand (2*WIDTH-bit add; cannot overflow).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the step where cnt==WIDTH-1: go to DONE and load out with the final acc (including this step's add).
  - cnt width is clog2(WIDTH)+1.
- DONE:
  - out and out_valid are held stable until out_ready=1 is sampled.
  - On that edge, go to IDLE. out keeps its value; only out_valid drops.
- Latency: acceptance at edge E gives out_valid=1 after edge E+WIDTH (4 cycles at default).
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH steps, handoff).
- Boundary rules:
  - in_valid while busy: ignored (in_ready=0). The source must hold its operands.
  - x or y changing during CALC/DONE: no effect, because operands are registered.
  - out_ready=1 outside DONE: ignored.
  - Accept and handoff never occur on the same edge: there is no IDLE bypass from DONE.
  - x=0 or y=0: product is 0 and normal latency applies (unless the optional feature is enabled).
  - Maximum operands: product is (2^WIDTH-1)^2, which fits in 2*WIDTH bits with no truncation.
- No X may propagate to any output after reset deassertion.

Optional Feature:
- Macro: MULT_SEQ_EARLY_EXIT_EN.
- Defined:
  - In CALC, go to DONE on any step where the shifted mplier becomes 0, or cnt==WIDTH-1.
  - Latency = max(1, index of the highest set bit of y + 1) cycles.
  - Examples: y=0 or y=1 gives 1 cycle; y=4'b1000 gives 4 cycles.
  - Product value is identical to the non-early-exit result.
- Not defined: fixed WIDTH-cycle latency as above. No early-exit logic is synthesized.

Test Plan:
- Reset then x=4'b1000, y=4'b1001 with in_valid pulse and out_ready=1:
  - out=8'h48 (72) with out_valid high exactly 4 cycles after acceptance.
  - busy high for 5 cycles.
- x=4'b1101, y=4'b0110:
  - out=8'h4E (78).
  - Then x=4'hF, y=4'hF back-to-back with in_valid held: out=8'hE1 (225).
  - Second acceptance occurs one cycle after the first handoff.
- Backpressure: x=3, y=5, out_ready=0 for 10 cycles after out_valid:
  - out=8'h0F held stable with out_valid=1 and in_ready=0 throughout.
  - New in_valid is ignored until the handoff edge.
- Zero operands: x=0, y=7 -> out=0 after 4 cycles. Then x=9, y=0 -> out=0 after 4 cycles.
- Reset mid-op: assert rst_n=0 asynchronously (between edges) during cycle 2 of CALC for x=6, y=7:
  - out=0, out_valid=0, busy=0, in_ready=1 immediately.
  - A new operation x=2, y=3 after release returns out=6.
- With MULT_SEQ_EARLY_EXIT_EN:
  - y=1, x=5 -> out=5 after 1 cycle.
  - y=0 -> 1 cycle.
  - y=4'b1000, x=3 -> out=8'h18 after 4 cycles.
  - Exhaustive 16x16 sweep matches x*y.

Source files
------------

// File: rtl/mult_seq_4b.sv
// ============================================================================
// Module   : mult_seq_4b
// Brief    : Multi-cycle shift-and-add unsigned multiplier with valid/ready
//            handshakes on input and output. Produces the full 2*WIDTH-bit
//            product. Optional macro MULT_SEQ_EARLY_EXIT_EN ends the
//            calculation as soon as the remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_4b #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]     w_mplier_nxt;
  logic                 w_finish;

  // Next partial product and the end-of-calculation decision for this step
  always_comb begin
    w_sum        = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_nxt = r_mplier >> 1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    w_finish     = (r_cnt == c_LAST) || (w_mplier_nxt == '0);
`else
    w_finish     = (r_cnt == c_LAST);
`endif
  end

  // Control FSM plus datapath registers; out is only loaded on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, x};
            r_mplier <= y;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_finish) begin
            r_out   <= w_sum;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Handoff returns to IDLE only; a new accept needs a further edge
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_4b.sv
// ============================================================================
// Module   : tb_mult_seq_4b
// Brief    : Self-checking bench for mult_seq_4b. Expected products and
//            latencies come from plain arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_4b;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           busy;

  int n_cmp;
  int n_fail;

  mult_seq_4b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference latency: cycles from acceptance to out_valid
  function automatic int exp_lat(input int b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) if (((b >> i) & 1) == 1) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return W;
`endif
  endfunction

  // One transaction, entered and left at a negedge in IDLE.
  // While busy, the input side is driven with (nv, na, nb) to show it is ignored.
  task automatic run_op(input int a, input int b, input int bp,
                        input logic nv, input int na, input int nb);
    int lat;
    logic [2*W-1:0] held;
    x         = W'(a);
    y         = W'(b);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = nv;
    x         = W'(na);
    y         = W'(nb);
    out_ready = (bp == 0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    for (int k = 1; k <= 2*W + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat(b)));
    chk("product", 32'(out), 32'(a * b));
    chk("busy_done", 32'(busy), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    held = out;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_stable", 32'(out), 32'(held));
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_out_valid", 32'(out_valid), 32'd0);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_busy", 32'(busy), 32'd0);
    chk("handoff_out_kept", 32'(out), 32'(held));
  endtask

  initial begin
    int a;
    int b;
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;

    // Reset state
    #2;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product 8*9
    run_op(8, 9, 0, 1'b0, 0, 0);

    // 13*6 with in_valid held and 15*15 staged behind it: back-to-back issue
    run_op(13, 6, 0, 1'b1, 15, 15);
    run_op(15, 15, 0, 1'b0, 0, 0);

    // Backpressure with a competing request held during DONE
    run_op(3, 5, 10, 1'b1, 12, 11);

    // Zero operands
    run_op(0, 7, 0, 1'b0, 0, 0);
    run_op(9, 0, 0, 1'b0, 0, 0);

    // Latency-sensitive y patterns
    run_op(5, 1, 0, 1'b0, 0, 0);
    run_op(3, 8, 0, 1'b0, 0, 0);
    run_op(15, 0, 0, 1'b0, 0, 0);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(i, j, 0, 1'b0, 0, 0);

    // Randomized operands, backpressure and ignored side traffic
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      run_op(a, b, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
             int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    // Leave a non-zero product in out before the asynchronous reset
    run_op(3, 5, 0, 1'b0, 0, 0);

    // Asynchronous reset during the second CALC cycle of 6*7
    x        = 4'd6;
    y        = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2, 3, 0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
